// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus bit offsets for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned EX2MEM_W = 173;
  localparam int unsigned MEM2WB_W = 167;
  localparam int unsigned MEM2ID_W = 39;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_H    = 3'd2,
    LD_W    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5
  } ld_op_e;

  // WB bus: {rf_we, rf_waddr, rf_wdata, pc, csr_re, csr_we, csr_num,
  //          csr_wmask, csr_wvalue, ertn, ex_en, ecode, esubcode}
  localparam int unsigned WB_EX_EN       = 15;
  localparam int unsigned WB_ERTN        = 16;
  localparam int unsigned WB_CSR_RE      = 96;
  localparam int unsigned WB_RF_WDATA_LO = 129;
  localparam int unsigned WB_RF_WADDR_LO = 161;
  localparam int unsigned WB_RF_WE       = 166;

endpackage

// File: rtl/mem_stage_load_fmt.sv
// Combinational load-data lane select and sign/zero extension.
module mem_load_fmt
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      LD_B:    wdata = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    wdata = {{16{half_sel[15]}}, half_sel};
      LD_BU:   wdata = {24'b0, byte_sel};
      LD_HU:   wdata = {16'b0, half_sel};
      default: wdata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM response, formats load data, forwards to ID.
// Optional MEM_LOAD_FWD_EN lets a load forward its data in the cycle its response is available.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_to_mem_valid,
  input  logic [EX2MEM_W-1:0] ex_to_mem_bus,
  output logic                mem_allowin,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  output logic                mem_to_wb_valid,
  output logic [MEM2WB_W-1:0] mem_to_wb_bus,
  input  logic                wb_allowin,
  input  logic                wb_ex,
  input  logic                ertn_flush,
  output logic [MEM2ID_W-1:0] mem_to_id_bus,
  output logic                mem_to_ex_bus,
  output logic                mem_wait_resp
);

  logic                flush;
  logic                mem_valid;
  logic                mem_ready_go;
  logic                data_ok_seen;
  logic                discard;
  logic                resp_avail;
  logic                fwd_block;
  logic [2:0]          ld_op;
  logic                mem_req;
  logic [1:0]          addr_lo;
  logic [MEM2WB_W-1:0] wb_fields;
  logic [31:0]         rdata_buf;
  logic [31:0]         resp_data;
  logic [31:0]         load_wdata;

  assign flush           = wb_ex | ertn_flush;
  assign resp_avail      = ~discard & (data_ok_seen | data_sram_data_ok);
  assign mem_ready_go    = ~mem_req | resp_avail;
  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go;
  assign resp_data       = data_ok_seen ? rdata_buf : data_sram_rdata;

  mem_load_fmt u_load_fmt (
    .ld_op   (ld_op),
    .addr_lo (addr_lo),
    .rdata   (resp_data),
    .wdata   (load_wdata)
  );

  always_comb begin
    mem_to_wb_bus = wb_fields;
    if (ld_op != LD_NONE) mem_to_wb_bus[WB_RF_WDATA_LO +: 32] = load_wdata;
    if (wb_fields[WB_EX_EN]) mem_to_wb_bus[WB_RF_WE] = 1'b0;
  end

`ifdef MEM_LOAD_FWD_EN
  assign fwd_block = mem_valid & (((ld_op != LD_NONE) & ~resp_avail) | wb_fields[WB_CSR_RE]);
`else
  assign fwd_block = mem_valid & ((ld_op != LD_NONE) | wb_fields[WB_CSR_RE]);
`endif

  assign mem_to_id_bus = {mem_valid & wb_fields[WB_RF_WE] & ~wb_fields[WB_EX_EN],
                          wb_fields[WB_RF_WADDR_LO +: 5],
                          mem_to_wb_bus[WB_RF_WDATA_LO +: 32],
                          fwd_block};
  assign mem_to_ex_bus = mem_valid & (wb_fields[WB_EX_EN] | wb_fields[WB_ERTN]);
  assign mem_wait_resp = discard | (mem_valid & mem_req & ~data_ok_seen);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid    <= 1'b0;
      ld_op        <= '0;
      mem_req      <= 1'b0;
      addr_lo      <= '0;
      wb_fields    <= '0;
      data_ok_seen <= 1'b0;
      rdata_buf    <= '0;
      discard      <= 1'b0;
    end else begin
      if (flush)            mem_valid <= 1'b0;
      else if (mem_allowin) mem_valid <= ex_to_mem_valid;

      if (ex_to_mem_valid & mem_allowin)
        {ld_op, mem_req, addr_lo, wb_fields} <= ex_to_mem_bus;

      // Hold a response that arrived while WB stalled until the instruction leaves.
      if (flush | (mem_to_wb_valid & wb_allowin)) begin
        data_ok_seen <= 1'b0;
      end else if (mem_valid & mem_req & ~discard & data_sram_data_ok & ~data_ok_seen) begin
        data_ok_seen <= 1'b1;
        rdata_buf    <= data_sram_rdata;
      end

      // A flushed request still owes one response; swallow it so no later load sees it.
      if (discard & data_sram_data_ok)
        discard <= 1'b0;
      else if (flush & mem_valid & mem_req & ~data_ok_seen & ~data_sram_data_ok)
        discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: load-format vector table, flush/stall sequences, random traffic.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ex_to_mem_valid = 1'b0;
  logic [172:0] ex_to_mem_bus = '0;
  logic         mem_allowin;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         mem_to_wb_valid;
  logic [166:0] mem_to_wb_bus;
  logic         wb_allowin = 1'b1;
  logic         wb_ex = 1'b0;
  logic         ertn_flush = 1'b0;
  logic [38:0]  mem_to_id_bus;
  logic         mem_to_ex_bus;
  logic         mem_wait_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .mem_allowin       (mem_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_allowin        (wb_allowin),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .mem_to_id_bus     (mem_to_id_bus),
    .mem_to_ex_bus     (mem_to_ex_bus),
    .mem_wait_resp     (mem_wait_resp)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk39(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk167(input string name, input logic [166:0] act, input logic [166:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [166:0] mk_wb(input logic rf_we, input logic [4:0] waddr,
                                         input logic [31:0] wdata, input logic [31:0] pc,
                                         input logic csr_re, input logic ertn,
                                         input logic ex_en, input logic [5:0] ecode);
    return {rf_we, waddr, wdata, pc, csr_re, 1'b0, 14'h0, 32'h0, 32'h0, ertn, ex_en, ecode, 9'h0};
  endfunction

  function automatic logic [172:0] mk_ex(input logic [2:0] op, input logic req,
                                         input logic [1:0] lo, input logic [166:0] wb);
    return {op, req, lo, wb};
  endfunction

  // Reference load formatting from plain arithmetic on the lane value.
  function automatic logic [31:0] ref_fmt(input logic [2:0] op, input logic [1:0] lo,
                                          input logic [31:0] rd);
    int unsigned b, h, sh_b, sh_h;
    sh_b = 8 * {30'b0, lo};
    sh_h = (lo >= 2'd2) ? 16 : 0;
    b = (rd >> sh_b) % 256;
    h = (rd >> sh_h) % 65536;
    case (op)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [172:0] bus);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = bus;
    step();
    ex_to_mem_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    logic [166:0] wb_r;
    logic [31:0]  r, rd, wdata, pc;
    logic [4:0]   waddr;
    logic [5:0]   ecode;
    logic [2:0]   op;
    logic [1:0]   lo;
    logic         req, rf_we, csr_re, ex_en, got, done, exp_v;
    int unsigned  delay, cyc;

    vecs[0] = '{3'd1, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[1] = '{3'd4, 2'd3, 32'h80FF_1234, 32'h0000_0080};
    vecs[2] = '{3'd5, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF};
    vecs[3] = '{3'd2, 2'd2, 32'h8000_1234, 32'hFFFF_8000};
    vecs[4] = '{3'd2, 2'd0, 32'hABCD_7FFF, 32'h0000_7FFF};
    vecs[5] = '{3'd1, 2'd1, 32'h0000_8000, 32'hFFFF_FF80};
    vecs[6] = '{3'd4, 2'd0, 32'h1234_56F0, 32'h0000_00F0};
    vecs[7] = '{3'd3, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8] = '{3'd6, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[9] = '{3'd7, 2'd3, 32'h0BAD_F00D, 32'h0BAD_F00D};

    // Reset state
    step();
    step();
    @(negedge clk);
    chk1("rst_wb_valid", mem_to_wb_valid, 1'b0);
    chk167("rst_wb_bus", mem_to_wb_bus, '0);
    chk39("rst_id_bus", mem_to_id_bus, '0);
    chk1("rst_ex_bus", mem_to_ex_bus, 1'b0);
    chk1("rst_wait", mem_wait_resp, 1'b0);
    chk1("rst_allowin", mem_allowin, 1'b1);
    step();
    resetn = 1'b1;

    // Load-format table, response in the first MEM cycle
    foreach (vecs[i]) begin
      enter(mk_ex(vecs[i].op, 1'b1, vecs[i].lo,
                  mk_wb(1'b1, 5'd3, 32'hFFFF_FFFF, 32'h1C00_0000, 1'b0, 1'b0, 1'b0, 6'h0)));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = vecs[i].rd;
      @(negedge clk);
      chk1("tbl_valid", mem_to_wb_valid, 1'b1);
      chk32("tbl_wdata", mem_to_wb_bus[160:129], vecs[i].exp);
      step();
      data_sram_data_ok = 1'b0;
    end

    // LD.HU with data_ok three cycles late
    enter(mk_ex(3'd5, 1'b1, 2'd2, mk_wb(1'b1, 5'd4, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0, 6'h0)));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("late_allowin", mem_allowin, 1'b0);
      chk1("late_valid", mem_to_wb_valid, 1'b0);
      chk1("late_wait", mem_wait_resp, 1'b1);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_0000;
    @(negedge clk);
    chk1("late_valid_ok", mem_to_wb_valid, 1'b1);
    chk32("late_wdata", mem_to_wb_bus[160:129], 32'h0000_BEEF);
    chk1("late_allowin_ok", mem_allowin, 1'b1);
    step();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk1("late_gone", mem_to_wb_valid, 1'b0);
    step();

    // Flush while waiting: first response discarded, second credited to the new load
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd8, 32'h0, 32'h20, 1'b0, 1'b0, 1'b0, 6'h0)));
    wb_ex = 1'b1;
    @(negedge clk);
    chk1("fl_valid", mem_to_wb_valid, 1'b0);
    step();
    wb_ex = 1'b0;
    @(negedge clk);
    chk1("fl_wait_discard", mem_wait_resp, 1'b1);
    chk1("fl_allowin", mem_allowin, 1'b1);
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd9, 32'h0, 32'h24, 1'b0, 1'b0, 1'b0, 6'h0)));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    @(negedge clk);
    chk1("fl_stale_dropped", mem_to_wb_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk1("fl_still_wait", mem_to_wb_valid, 1'b0);
    chk1("fl_wait_new", mem_wait_resp, 1'b1);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    @(negedge clk);
    chk1("fl_new_valid", mem_to_wb_valid, 1'b1);
    chk32("fl_new_wdata", mem_to_wb_bus[160:129], 32'h2222_2222);
    step();
    data_sram_data_ok = 1'b0;

    // Flush and new entry in the same cycle: flush wins
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = mk_ex(3'd0, 1'b0, 2'd0, mk_wb(1'b1, 5'd1, 32'h5, 32'h30, 1'b0, 1'b0, 1'b0, 6'h0));
    ertn_flush      = 1'b1;
    step();
    ex_to_mem_valid = 1'b0;
    ertn_flush      = 1'b0;
    @(negedge clk);
    chk1("flent_valid", mem_to_wb_valid, 1'b0);
    chk1("flent_allowin", mem_allowin, 1'b1);
    chk1("flent_fwd_we", mem_to_id_bus[38], 1'b0);
    step();

    // data_ok and flush together: response consumed, nothing left owed
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd2, 32'h0, 32'h34, 1'b0, 1'b0, 1'b0, 6'h0)));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    wb_ex             = 1'b1;
    step();
    data_sram_data_ok = 1'b0;
    wb_ex             = 1'b0;
    @(negedge clk);
    chk1("okfl_wait", mem_wait_resp, 1'b0);
    chk1("okfl_valid", mem_to_wb_valid, 1'b0);
    step();

    // Response arrives while WB stalls: buffered data shown later
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd10, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 6'h0)));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hA5A5_5A5A;
    wb_allowin        = 1'b0;
    @(negedge clk);
    chk1("buf_valid0", mem_to_wb_valid, 1'b1);
    chk1("buf_allowin0", mem_allowin, 1'b0);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    @(negedge clk);
    chk1("buf_valid1", mem_to_wb_valid, 1'b1);
    chk32("buf_wdata1", mem_to_wb_bus[160:129], 32'hA5A5_5A5A);
    step();
    wb_allowin = 1'b1;
    @(negedge clk);
    chk32("buf_wdata2", mem_to_wb_bus[160:129], 32'hA5A5_5A5A);
    chk1("buf_allowin2", mem_allowin, 1'b1);
    step();

    // Forwarding to ID
    enter(mk_ex(3'd0, 1'b0, 2'd0, mk_wb(1'b1, 5'd5, 32'd7, 32'h50, 1'b0, 1'b0, 1'b0, 6'h0)));
    @(negedge clk);
    chk39("fwd_add", mem_to_id_bus, {1'b1, 5'd5, 32'd7, 1'b0});
    step();
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd5, 32'h0, 32'h54, 1'b0, 1'b0, 1'b0, 6'h0)));
    @(negedge clk);
    chk39("fwd_ld_wait", mem_to_id_bus, {1'b1, 5'd5, 32'h0, 1'b1});
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_1234;
    @(negedge clk);
`ifdef MEM_LOAD_FWD_EN
    chk39("fwd_ld_resp", mem_to_id_bus, {1'b1, 5'd5, 32'h0000_1234, 1'b0});
`else
    chk39("fwd_ld_resp", mem_to_id_bus, {1'b1, 5'd5, 32'h0000_1234, 1'b1});
`endif
    step();
    data_sram_data_ok = 1'b0;
    enter(mk_ex(3'd0, 1'b0, 2'd0, mk_wb(1'b1, 5'd6, 32'd9, 32'h58, 1'b1, 1'b0, 1'b0, 6'h0)));
    @(negedge clk);
    chk39("fwd_csr", mem_to_id_bus, {1'b1, 5'd6, 32'd9, 1'b1});
    step();

    // Exception and ertn markers
    enter(mk_ex(3'd0, 1'b0, 2'd0, mk_wb(1'b1, 5'd7, 32'h55, 32'h60, 1'b0, 1'b0, 1'b1, 6'h0B)));
    @(negedge clk);
    chk1("exc_ex_bus", mem_to_ex_bus, 1'b1);
    chk167("exc_wb_bus", mem_to_wb_bus, mk_wb(1'b0, 5'd7, 32'h55, 32'h60, 1'b0, 1'b0, 1'b1, 6'h0B));
    chk1("exc_fwd_we", mem_to_id_bus[38], 1'b0);
    step();
    @(negedge clk);
    chk1("exc_gone", mem_to_ex_bus, 1'b0);
    enter(mk_ex(3'd0, 1'b0, 2'd0, mk_wb(1'b0, 5'd0, 32'h0, 32'h64, 1'b0, 1'b1, 1'b0, 6'h0)));
    @(negedge clk);
    chk1("ertn_ex_bus", mem_to_ex_bus, 1'b1);
    step();

    // Reset while a flushed response is owed
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd11, 32'h0, 32'h70, 1'b0, 1'b0, 1'b0, 6'h0)));
    wb_ex = 1'b1;
    step();
    wb_ex = 1'b0;
    @(negedge clk);
    chk1("rmw_wait_pre", mem_wait_resp, 1'b1);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk1("rmw_wait_post", mem_wait_resp, 1'b0);
    step();

    // Reset with a buffered response: nothing survives, next load must wait for its own
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd12, 32'h0, 32'h74, 1'b0, 1'b0, 1'b0, 6'h0)));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h4444_4444;
    wb_allowin        = 1'b0;
    step();
    data_sram_data_ok = 1'b0;
    resetn            = 1'b0;
    step();
    resetn     = 1'b1;
    wb_allowin = 1'b1;
    @(negedge clk);
    chk1("rbuf_valid", mem_to_wb_valid, 1'b0);
    chk167("rbuf_bus", mem_to_wb_bus, '0);
    chk39("rbuf_id", mem_to_id_bus, '0);
    enter(mk_ex(3'd3, 1'b1, 2'd0, mk_wb(1'b1, 5'd13, 32'h0, 32'h78, 1'b0, 1'b0, 1'b0, 6'h0)));
    @(negedge clk);
    chk1("rbuf_no_stale", mem_to_wb_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    @(negedge clk);
    chk32("rbuf_own_data", mem_to_wb_bus[160:129], 32'h5555_5555);
    step();
    data_sram_data_ok = 1'b0;

    // Random traffic against the transaction-level model
    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      op     = r[2:0];
      lo     = r[4:3];
      rf_we  = r[5];
      csr_re = r[6];
      ex_en  = (r[10:8] == 3'd0);
      waddr  = r[15:11];
      ecode  = r[21:16];
      req    = (op != 3'd0);
      delay  = {30'b0, r[23:22]};
      rd     = $urandom;
      wdata  = $urandom;
      pc     = $urandom;
      enter(mk_ex(op, req, lo, mk_wb(rf_we, waddr, wdata, pc, csr_re, 1'b0, ex_en, ecode)));
      wb_r = mk_wb(rf_we & ~ex_en, waddr, req ? ref_fmt(op, lo, rd) : wdata,
                   pc, csr_re, 1'b0, ex_en, ecode);
      got  = 1'b0;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 20) begin
        data_sram_data_ok = req && !got && (cyc == delay);
        data_sram_rdata   = data_sram_data_ok ? rd : $urandom;
        wb_allowin        = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        exp_v = !req || got || data_sram_data_ok;
        chk1("rnd_valid", mem_to_wb_valid, exp_v);
        chk1("rnd_allowin", mem_allowin, exp_v && wb_allowin);
        chk1("rnd_fwd_we", mem_to_id_bus[38], rf_we & ~ex_en);
        if (exp_v) chk167("rnd_bus", mem_to_wb_bus, wb_r);
        if (exp_v && wb_allowin) done = 1'b1;
        if (data_sram_data_ok) got = 1'b1;
        step();
        cyc++;
      end
      data_sram_data_ok = 1'b0;
      wb_allowin        = 1'b1;
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout: instruction %0d still in MEM after %0d cycles, required to leave", k, cyc);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
